// File: rtl/sbox_share_driver.sv
// sbox_share_driver
// -----------------
// Masking front-end and unmasking back-end for a 4-bit masked Skinny S-box
// core at security order 3. It accepts one plain nibble, splits it into four
// Boolean shares, restarts the core and waits for the core's Synch. It then
// recombines the four output shares into a plain result nibble.
//
// Parameters
//   LFSR_SEED : initial 40-bit LFSR state. A seed of 0 is replaced by 1.
//   TIMEOUT   : maximum number of WAIT cycles before the block aborts.
//               It is used only when SBOX_DRV_TIMEOUT_EN is defined.
//
// Optional feature macro: SBOX_DRV_TIMEOUT_EN
//   When it is defined, WAIT is bounded by TIMEOUT and err pulses on an abort.
//   When it is undefined, WAIT has no bound and err is tied to 0.
//
// Ports
//   clk, rst               : single clock; synchronous active-high reset.
//   in_valid/in_ready      : input handshake; in_data is the unmasked nibble.
//   out_valid/out_ready    : output handshake; out_data is the unmasked result.
//   err                    : one-cycle pulse on a timeout abort.
//   X_s0..X_s3             : input shares to the core.
//   Fresh                  : 24-bit randomness to the core.
//   sbox_rst               : restart of the core.
//   Y_s0..Y_s3             : output shares from the core.
//   Synch                  : result-ready indication from the core.
//   dbg_state              : current FSM state (0 IDLE, 1 LOAD, 2 WAIT, 3 DONE).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE and only while rst is low.
// out_valid is high only in DONE. While out_valid is high, out_data does not
// change, whatever the state of out_ready.
module sbox_share_driver #(
  parameter logic [39:0] LFSR_SEED = 40'h00_0000_0001,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        err,
  output logic [3:0]  X_s0,
  output logic [3:0]  X_s1,
  output logic [3:0]  X_s2,
  output logic [3:0]  X_s3,
  output logic [23:0] Fresh,
  output logic        sbox_rst,
  input  logic [3:0]  Y_s0,
  input  logic [3:0]  Y_s1,
  input  logic [3:0]  Y_s2,
  input  logic [3:0]  Y_s3,
  input  logic        Synch,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [39:0] SEED = (LFSR_SEED == 40'd0) ? 40'd1 : LFSR_SEED;

  state_t      state;
  logic [39:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci LFSR with taps 40,38,21,19. It runs every cycle outside reset,
  // including while the output is backpressured. Its state never reaches 0.
  assign lfsr_fb = lfsr[39] ^ lfsr[37] ^ lfsr[20] ^ lfsr[18];

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[38:0], lfsr_fb};
  end

`ifdef SBOX_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      X_s0     <= '0;
      X_s1     <= '0;
      X_s2     <= '0;
      X_s3     <= '0;
      Fresh    <= '0;
      out_data <= '0;
`ifdef SBOX_DRV_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef SBOX_DRV_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Shares and Fresh are updated only on this edge. They then hold
          // until the next accept, because the core's gadgets need Fresh held
          // constant for the whole evaluation.
          if (in_valid) begin
            X_s1  <= lfsr[3:0];
            X_s2  <= lfsr[7:4];
            X_s3  <= lfsr[11:8];
            X_s0  <= in_data ^ lfsr[3:0] ^ lfsr[7:4] ^ lfsr[11:8];
            Fresh <= lfsr[35:12];
            state <= LOAD;
          end
        end
        LOAD: begin
`ifdef SBOX_DRV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // If Synch and the timeout arrive in the same cycle, Synch wins.
          if (Synch) begin
            out_data <= Y_s0 ^ Y_s1 ^ Y_s2 ^ Y_s3;
            state    <= DONE;
          end
`ifdef SBOX_DRV_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  // While the driver is in reset, the core is held in reset too.
  assign sbox_rst  = rst || (state == LOAD);
  assign dbg_state = state;

endmodule

// File: doc/sbox_share_driver.md
# sbox_share_driver

Front-end/back-end wrapper for the masked 4-bit Skinny S-box core at security order 3. It accepts an unmasked nibble over a valid/ready handshake and splits it into four Boolean shares. It drives the core's share inputs, its 24-bit `Fresh` randomness and its restart (`rst`), then waits for the core's `Synch` pulse. It recombines the four output shares into a plain nibble, acting as the encoder/decoder on the other side of the core's share interface.

## Interface
Parameters:
- `LFSR_SEED`, 40'h00_0000_0001: initial LFSR state; a value of 0 is replaced by 1.
- `TIMEOUT`, 16: maximum WAIT cycles before abort; used only with `SBOX_DRV_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; drives this block and the core.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input nibble valid.
- `in_ready` out 1: block can accept a nibble.
- `in_data` in 4: unmasked S-box input.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 4: unmasked S-box output.
- `err` out 1: one-cycle pulse on timeout abort.
- `X_s0`, `X_s1`, `X_s2`, `X_s3` out 4 each: input shares to the core.
- `Fresh` out 24: randomness to the core.
- `sbox_rst` out 1: restart of the core's clock-gating controller.
- `Y_s0`, `Y_s1`, `Y_s2`, `Y_s3` in 4 each: output shares from the core.
- `Synch` in 1: core result-ready indication.

## Operation
- **LFSR**
  - 40-bit Fibonacci LFSR, taps 40,38,21,19; shifts every cycle that `rst` is low.
  - `lfsr[11:0]` supplies the share masks; `lfsr[35:12]` supplies `Fresh`.
- **FSM states:** IDLE, LOAD, WAIT, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid & in_ready`, register the shares and go to LOAD:
    - `X_s1=lfsr[3:0]`, `X_s2=lfsr[7:4]`, `X_s3=lfsr[11:8]`.
    - `X_s0=in_data^X_s1^X_s2^X_s3`.
    - `Fresh=lfsr[35:12]`.
- **LOAD**
  - `sbox_rst=1` for exactly this one cycle.
  - Go to WAIT and clear the wait counter.
- **WAIT**
  - `sbox_rst=0`; increment the wait counter.
  - When `Synch` is sampled high: `out_data <= Y_s0^Y_s1^Y_s2^Y_s3`, then go to DONE.
- **DONE**
  - `out_valid=1`; `out_data` is held stable.
  - On `out_ready`, go to IDLE.
- **Share and `Fresh` stability:** `X_s*` and `Fresh` change only on the IDLE accept edge and hold through LOAD, WAIT and DONE. The core's HPC2 gadgets need `Fresh` constant for the whole evaluation.
- **`Synch` outside WAIT:** ignored, with no state change.
- **Masking rule:** the unmasked `in_data` is never routed to any output except through `X_s0`. `out_data` is the only point where shares are recombined.
- **`sbox_rst`:** equals `rst | (state==LOAD)`, so the core is held in reset while the driver is in reset.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready=0` while `rst` is high, and 1 from the first cycle after.
  - `out_valid=0`, `out_data=0`, `err=0`.
  - `X_s*=0`, `Fresh=0`.
  - LFSR = `LFSR_SEED`.
- **Latency:**
  - Accept edge to LOAD: 1 cycle.
  - LOAD to WAIT: 1 cycle.
  - WAIT to DONE: the core's latency (5 gated cycles at order 3) plus 1 cycle for the registered capture.
- **Throughput:** one nibble in flight; the next accept is possible in the cycle after the `out_valid & out_ready` handshake.
- **Reset mid-operation:** any state returns to IDLE in one cycle and any pending result is discarded.
- **Backpressure:** `out_ready` held low keeps DONE indefinitely; the LFSR keeps running.
- **LFSR wrap:** the period is 2^40−1; the all-zero state is unreachable.

## Configuration
- **Macro:** `SBOX_DRV_TIMEOUT_EN`.
- **Defined:**
  - A wait counter of width `$clog2(TIMEOUT+1)` counts cycles in WAIT.
  - If it reaches `TIMEOUT` with `Synch` still low: pulse `err` for 1 cycle, go to IDLE, and leave `out_valid` low.
  - `Synch` and timeout in the same cycle: `Synch` wins.
- **Undefined:** WAIT has no bound, `err` is tied to 0, and no counter is instantiated.

## Test plan
- **Reset:** `rst` held 3 cycles → all outputs hold their reset values, `sbox_rst=1` throughout, `in_ready` rises the cycle after release.
- **Functional vectors:** drive `in_data=0x0`, `0x5`, `0xF` with `out_ready=1` → `out_data=0xC`, `0xA`, `0xF` respectively. For each, check `X_s0^X_s1^X_s2^X_s3 == in_data` and that `sbox_rst` is high for exactly 1 cycle.
- **Exhaustive with backpressure:** all 16 inputs, `out_ready` low for 4 cycles in DONE → `out_data` is stable and equals Skinny S(x) (c,6,9,0,1,a,2,b,3,8,5,d,4,e,7,f). `Fresh` and `X_s*` are unchanged from accept to handshake.
- **Reset mid-WAIT:** assert `rst` 2 cycles after LOAD → IDLE next cycle, `out_valid` never asserts, and the next request `0x3` returns `0x0`.
- **Timeout (`SBOX_DRV_TIMEOUT_EN` defined):** `TIMEOUT=8` with `Synch` forced low → `err` is a 1-cycle pulse 8 cycles into WAIT, the FSM is in IDLE, and `out_valid` stays 0.
- **Stray `Synch`:** pulse `Synch` while in IDLE and while in DONE → no state change and no new capture.
